ahb_image_buffer_slave: RTL

AHB-Lite slave for the Sobel edge pipeline. It sits directly downstream of the slave address decoder and is selected by the decoder's image-buffer select (HSEL_2). It accepts 32-bit words of packed 8-bit grayscale pixels into a word FIFO and unpacks them LSB-byte-first onto a valid/ready pixel stream for the convolution engine. It returns `shift_data` (space available) to the decoder and `conv_ready` (enough pixels buffered) to the MCU control path.

---
 rtl/ahb_image_buffer_slave.sv | 89 ++++++++
 1 files changed

// File: rtl/ahb_image_buffer_slave.sv
// AHB-Lite image-buffer slave: word FIFO that unpacks LSB-byte-first onto a pixel stream.
// Optional status-word read path is compiled in with IMGBUF_STATUS_READ_EN.
module ahb_image_buffer_slave #(
  parameter int DEPTH       = 8,
  parameter int CONV_THRESH = 3
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        HRESP,
  output logic [7:0]  pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        shift_data,
  output logic        conv_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] THRESH   = CW'(CONV_THRESH);

  logic [DEPTH-1:0][31:0] mem_q;
  logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]          count_q, count_d;
  logic [1:0]             byte_idx_q;
  logic                   wr_pend_q, rd_pend_q;
  logic                   full, empty, accept, push, hs, pop;
  logic                   unused_sig;

  always_comb begin
    full    = (count_q == FULL_CNT);
    empty   = (count_q == '0);
    accept  = HSEL & HREADY & HTRANS[1];
    push    = wr_pend_q & HREADY & ~full;
    hs      = ~empty & pix_ready;
    pop     = hs & (byte_idx_q == 2'd3);
    count_d = count_q;
    if (push & ~pop)      count_d = count_q + CW'(1);
    else if (pop & ~push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      byte_idx_q <= '0;
      wr_pend_q  <= 1'b0;
      rd_pend_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (hs)   byte_idx_q <= byte_idx_q + 2'd1;
      // A stalled write holds the bus low, so pending state only moves when HREADY is high.
      if (HREADY) begin
        wr_pend_q <= accept & HWRITE;
        rd_pend_q <= accept & ~HWRITE;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (push) mem_q[wr_ptr_q] <= HWDATA;
  end

  assign HREADYOUT  = ~(wr_pend_q & full);
  assign HRESP      = 1'b0;
  assign pix_valid  = ~empty;
  assign pix_data   = empty ? 8'h00 : mem_q[rd_ptr_q][8*byte_idx_q +: 8];
  assign shift_data = ~full;
  assign conv_ready = (count_q >= THRESH);

`ifdef IMGBUF_STATUS_READ_EN
  assign HRDATA     = rd_pend_q ? {14'b0, byte_idx_q, 8'(count_q), 6'b0, full, empty} : 32'h0;
  assign unused_sig = HTRANS[0];
`else
  assign HRDATA     = 32'h0;
  assign unused_sig = ^{HTRANS[0], rd_pend_q};
`endif

endmodule
